// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto one single-ported memory bus, one transaction in flight.
// Optional round-robin arbitration: define MEM_ARB_ROUND_ROBIN_EN (default is fixed ls-over-if priority).
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_done,
  output logic                err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int STRB_W = DATA_W / 8;
  // Timeout fires in the TIMEOUT_CYCLES-th WAIT cycle without a response.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mreq_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d, pick;
  logic [15:0]       cnt_q, cnt_d;
  mreq_t             mreq_q, mreq_d, if_mreq, ls_mreq;
  logic              mem_req_q, mem_req_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic              if_done_q, if_done_d, ls_done_q, ls_done_d;
  logic              err_q, err_d;
  logic              fin, fin_err;
  logic [DATA_W-1:0] fin_data;

  assign if_mreq = '{we: 1'b0, addr: if_addr, wdata: '0, wstrb: '0};
  assign ls_mreq = '{we: ls_we, addr: ls_addr, wdata: ls_wdata,
                     wstrb: ls_we ? ls_wstrb : '0};

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t last_q;

  always_ff @(posedge clk or posedge rst)
    if (rst)                 last_q <= OWN_IF;
    else if (state_q == DONE) last_q <= owner_q;

  always_comb begin
    if (ls_req && if_req) pick = (last_q == OWN_LS) ? OWN_IF : OWN_LS;
    else if (ls_req)      pick = OWN_LS;
    else                  pick = OWN_IF;
  end
`else
  always_comb pick = ls_req ? OWN_LS : OWN_IF;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    mreq_d     = mreq_q;
    mem_req_d  = mem_req_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    err_d      = 1'b0;
    fin        = 1'b0;
    fin_err    = 1'b0;
    fin_data   = '0;
    case (state_q)
      IDLE: if (if_req || ls_req) begin
        owner_d   = pick;
        mreq_d    = (pick == OWN_LS) ? ls_mreq : if_mreq;
        mem_req_d = 1'b1;
        state_d   = ISSUE;
      end
      ISSUE: if (mem_gnt) begin
        mem_req_d = 1'b0;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          fin      = 1'b1;
          fin_data = mreq_q.we ? '0 : mem_rdata;
        end else if (cnt_q == TO_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;  // DONE: requests ignored so the owner can drop req
    endcase
    if (fin) begin
      state_d = DONE;
      err_d   = fin_err;
      if (owner_q == OWN_LS) begin
        ls_rdata_d = fin_data;
        ls_done_d  = 1'b1;
      end else begin
        if_rdata_d = fin_data;
        if_done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      cnt_q      <= '0;
      mreq_q     <= '0;
      mem_req_q  <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      mreq_q     <= mreq_d;
      mem_req_q  <= mem_req_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      err_q      <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mreq_q.we;
  assign mem_addr  = mreq_q.addr;
  assign mem_wdata = mreq_q.wdata;
  assign mem_wstrb = mreq_q.wstrb;
  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_done   = ls_done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (fixed-priority build, TIMEOUT_CYCLES=8).
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 0, if_done, ls_req = 0, ls_we = 0, ls_done, err;
  logic [31:0] if_addr = 0, if_rdata, ls_addr = 0, ls_wdata = 0, ls_rdata;
  logic [3:0]  ls_wstrb = 0, mem_wstrb;
  logic        mem_req, mem_we, mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  int n_cmp = 0, n_err = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_rdata(ls_rdata), .ls_done(ls_done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in an ISSUE cycle: grant now, respond after wait_cycles idle WAIT cycles.
  // Returns in the cycle where done is visible.
  task automatic serve(input logic [31:0] d, input int wait_cycles);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    repeat (wait_cycles) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_ls_done", ls_done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();

    // single fetch, rvalid two cycles after grant
    if_req = 1; if_addr = 32'h40;
    tick();
    chk("f_mem_req", mem_req, 1);
    chk("f_mem_addr", mem_addr, 32'h40);
    chk("f_mem_we", mem_we, 0);
    chk("f_mem_wstrb", mem_wstrb, 0);
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    chk("f_req_drop", mem_req, 0);
    tick();
    chk("f_no_early_done", if_done, 0);
    mem_rvalid = 1; mem_rdata = 32'h2408_0005;
    tick();
    mem_rvalid = 0;
    chk("f_done", if_done, 1);
    chk("f_rdata", if_rdata, 32'h2408_0005);
    chk("f_err", err, 0);
    chk("f_ls_done", ls_done, 0);
    if_req = 0;
    tick();
    chk("f_done_pulse", if_done, 0);
    chk("f_idle_req", mem_req, 0);

    // store then load at 0x100
    ls_req = 1; ls_we = 1; ls_addr = 32'h100; ls_wdata = 32'hCAFE_F00D; ls_wstrb = 4'b0011;
    tick();
    chk("st_mem_req", mem_req, 1);
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_addr", mem_addr, 32'h100);
    chk("st_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("st_mem_wstrb", mem_wstrb, 4'b0011);
    serve(32'hDEAD_BEEF, 0);
    chk("st_done", ls_done, 1);
    chk("st_rdata_zero", ls_rdata, 0);
    ls_req = 0;
    tick();
    ls_req = 1; ls_we = 0;
    tick();
    chk("ld_mem_we", mem_we, 0);
    chk("ld_mem_wstrb", mem_wstrb, 0);
    serve(32'h0000_F00D, 1);
    chk("ld_done", ls_done, 1);
    chk("ld_rdata", ls_rdata, 32'h0000_F00D);
    chk("ld_if_hold", if_rdata, 32'h2408_0005);
    chk("ld_if_done", if_done, 0);
    ls_req = 0;
    tick();

    // contention: ls first, then if
    if_req = 1; if_addr = 32'h80; ls_req = 1; ls_we = 0; ls_addr = 32'h200;
    tick();
    chk("c1_addr", mem_addr, 32'h200);
    serve(32'h11, 0);
    chk("c1_ls_done", ls_done, 1);
    chk("c1_if_done", if_done, 0);
    chk("c1_rdata", ls_rdata, 32'h11);
    ls_req = 0;
    tick();
    tick();
    chk("c2_req", mem_req, 1);
    chk("c2_addr", mem_addr, 32'h80);
    serve(32'h22, 0);
    chk("c2_if_done", if_done, 1);
    chk("c2_ls_done", ls_done, 0);
    chk("c2_rdata", if_rdata, 32'h22);
    if_req = 0;
    tick();

    // grant stall: five cycles without gnt
    if_req = 1; if_addr = 32'h300;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("gs_mem_req", mem_req, 1);
      chk("gs_mem_addr", mem_addr, 32'h300);
      chk("gs_no_done", if_done, 0);
      if (i == 5) mem_gnt = 1;
      tick();
    end
    mem_gnt = 0;
    chk("gs_wait_no_done", if_done, 0);
    mem_rvalid = 1; mem_rdata = 32'h33;
    tick();
    mem_rvalid = 0;
    chk("gs_done", if_done, 1);
    chk("gs_rdata", if_rdata, 32'h33);
    if_req = 0;
    tick();

    // timeout: no rvalid, done+err 8 cycles after the grant edge
    ls_req = 1; ls_we = 0; ls_addr = 32'h400;
    tick();
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    for (int i = 0; i < 8; i++) begin
      chk("to_not_yet", ls_done, 0);
      tick();
    end
    chk("to_done", ls_done, 1);
    chk("to_err", err, 1);
    chk("to_rdata", ls_rdata, 0);
    ls_req = 0;
    tick();
    chk("to_err_pulse", err, 0);
    if_req = 1; if_addr = 32'h500;
    tick();
    chk("to_next_addr", mem_addr, 32'h500);
    serve(32'h55, 0);
    chk("to_next_done", if_done, 1);
    chk("to_next_err", err, 0);
    chk("to_next_rdata", if_rdata, 32'h55);
    if_req = 0;
    tick();

    // async reset in WAIT, then a stale rvalid
    ls_req = 1; ls_addr = 32'h600;
    tick();
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    #2 rst = 1;
    #1;
    chk("ar_mem_addr", mem_addr, 0);
    chk("ar_if_rdata", if_rdata, 0);
    chk("ar_mem_req", mem_req, 0);
    tick();
    rst = 0; ls_req = 0;
    mem_rvalid = 1; mem_rdata = 32'h66;
    tick();
    mem_rvalid = 0;
    chk("ar_stale_ls_done", ls_done, 0);
    chk("ar_stale_if_done", if_done, 0);
    tick();
    chk("ar_stale_ls_done2", ls_done, 0);
    chk("ar_ls_rdata", ls_rdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
